// File: rtl/pattern_serializer_if.sv
// Symbol/config/serial bus of the pattern serializer.
// master = symbol/config source, slave = serializer.
interface pattern_serializer_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8
);
    logic [IN_W-1:0]  data;
    logic             data_valid;
    logic             data_ready;
    logic             cfg_we;
    logic [IN_W-1:0]  cfg_addr;
    logic [OUT_W-1:0] cfg_data;
    logic [OUT_W-1:0] data_out;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             busy;

    modport master (
        output data, data_valid, cfg_we, cfg_addr, cfg_data,
        input  data_ready, data_out, ser_out, ser_valid, frame_start, busy
    );

    modport slave (
        input  data, data_valid, cfg_we, cfg_addr, cfg_data,
        output data_ready, data_out, ser_out, ser_valid, frame_start, busy
    );
endinterface

// File: rtl/pattern_serializer.sv
// Pattern serializer: maps a symbol index through a writable codeword table
// and shifts the codeword out one bit per cycle, back-to-back when fed on
// the last bit of the previous codeword.
module pattern_serializer #(
    parameter int IN_W      = 4,
    parameter int OUT_W     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pattern_serializer_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << IN_W;
    localparam int          CW    = $clog2(OUT_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(OUT_W - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [OUT_W-1:0] sreg;
    logic [OUT_W-1:0] dout_q;
    logic [OUT_W-1:0] tbl [DEPTH];
    logic             ready;
    logic             accept;
    logic             shifting;

    // Power-on codeword table contents, truncated to the codeword width.
    function automatic logic [OUT_W-1:0] reset_entry(input int unsigned idx);
        logic [31:0] v;
        case (idx)
            1:       v = 32'h96;
            2:       v = 32'h8E;
            3:       v = 32'hE5;
            default: v = '0;
        endcase
        return v[OUT_W-1:0];
    endfunction

    assign shifting = (state == SHIFT);
    assign ready    = reset_n && (!shifting || (cnt == '0));
    assign accept   = bus.data_valid && ready;

    // Codeword table: restored on reset, otherwise written by the config port.
    // A same-cycle lookup sees the old entry because both update on the edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl[i] <= reset_entry(i);
            end
        end else if (bus.cfg_we) begin
            tbl[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    // Control FSM, bit counter, shift register and parallel output register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sreg   <= '0;
            dout_q <= '0;
        end else if (accept) begin
            state  <= SHIFT;
            cnt    <= CNT_LAST;
            sreg   <= tbl[bus.data];
            dout_q <= tbl[bus.data];
        end else if (shifting) begin
            if (cnt == '0) begin
                state <= IDLE;
            end else begin
                cnt <= cnt - 1'b1;
            end
            sreg <= (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
        end
    end

    assign bus.data_ready  = ready;
    assign bus.data_out    = dout_q;
    assign bus.ser_valid   = shifting;
    assign bus.busy        = shifting;
    assign bus.frame_start = shifting && (cnt == CNT_LAST);
    assign bus.ser_out     = shifting &&
                             ((MSB_FIRST != 0) ? sreg[OUT_W-1] : sreg[0]);
endmodule

// File: doc/pattern_serializer.md
PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

Interface
REQ-001 Parameter IN_W, default 4, symbol index width.
REQ-002 Parameter OUT_W, default 8, codeword width; legal range 2..32.
REQ-003 Parameter MSB_FIRST, default 1; 1 = codeword MSB shifted first, 0 = LSB first.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset, sampled on rising clk edge.
REQ-006 data  input  IN_W  symbol index into codeword table.
REQ-007 data_valid  input  1  symbol present on data.
REQ-008 data_ready  output  1  block can accept a symbol this cycle.
REQ-009 cfg_we  input  1  table write strobe.
REQ-010 cfg_addr  input  IN_W  table write address.
REQ-011 cfg_data  input  OUT_W  table write data.
REQ-012 data_out  output  OUT_W  registered parallel codeword of the last accepted symbol.
REQ-013 ser_out  output  1  serial codeword bit.
REQ-014 ser_valid  output  1  ser_out carries a valid bit.
REQ-015 frame_start  output  1  high on the first serial bit of each codeword.
REQ-016 busy  output  1  high while in SHIFT.

Function
REQ-017 Table: 2**IN_W entries of OUT_W bits; entries written only through cfg_we/cfg_addr/cfg_data.
REQ-018 Table write takes effect at the clock edge; a write and a lookup of the same address in the same cycle use the old contents.
REQ-019 Table writes are legal in any state and affect only symbols accepted afterwards; an in-flight codeword is unaffected.
REQ-020 FSM states: IDLE, SHIFT.
REQ-021 data_ready = 1 in IDLE, and in SHIFT only when the bit counter is 0 (last bit); 0 otherwise.
REQ-022 Accept = data_valid && data_ready; data_valid without data_ready is ignored and not stored.
REQ-023 On accept: shift register <= table[data], data_out <= table[data], bit counter <= OUT_W-1, state <= SHIFT.
REQ-024 Latency: symbol accepted at edge N -> first bit on ser_out with ser_valid=1 and frame_start=1 in the cycle after edge N.
REQ-025 SHIFT: ser_valid=1, ser_out = shift-register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0); shift by one and decrement counter each cycle.
REQ-026 Each codeword occupies exactly OUT_W consecutive ser_valid cycles; frame_start high only in the first of them.
REQ-027 Counter 0 with no accept -> IDLE next cycle; counter 0 with accept -> reload and stay in SHIFT, giving a gap-free back-to-back stream.
REQ-028 IDLE: ser_valid=0, frame_start=0, ser_out=0, busy=0; data_out holds its last value.
REQ-029 An all-zero codeword is serialised normally (OUT_W zero bits with ser_valid=1).

Reset
REQ-030 reset_n=0 at a clock edge: state <= IDLE, counter <= 0, shift register <= 0, data_out <= 0, ser_out/ser_valid/frame_start/busy <= 0.
REQ-031 Reset table contents: entry 1 = 0x96, entry 2 = 0x8E, entry 3 = 0xE5, all others 0 (entries truncated/zero-extended to OUT_W).
REQ-032 Reset mid-codeword aborts it; no further bits of that codeword appear; reset takes priority over accept and cfg_we in the same cycle.
REQ-033 data_ready is 0 while reset_n=0 and 1 in the first cycle after release.

Verification
REQ-034 Defaults, after reset, data=1 accepted at edge N -> cycles N+1..N+8 ser_out = 1,0,0,1,0,1,1,0, frame_start only at N+1, data_out=0x96.
REQ-035 Back-to-back: data=2 then data=3 held valid -> 16 contiguous ser_valid cycles, bits 10001110 11100101, frame_start at cycles 1 and 9, data_ready high only at cycles 0 and 8.
REQ-036 cfg_we with addr=5, data=0xA5 in the same cycle as accept of data=5 -> 0x00 serialised; next accept of 5 -> 10100101.
REQ-037 MSB_FIRST=0, data=3 -> bits 1,0,1,0,0,1,1,1.
REQ-038 reset_n=0 at the 4th bit of a codeword -> ser_valid=0 next cycle, data_out=0, table restored to its reset contents.
REQ-039 data_valid held while busy and not on the last bit -> no accept, no stored symbol; accept occurs at the last bit only.
